// File: rtl/fprint_compare_unit.sv
// Fingerprint comparison control for a DMR core pair: CSR file, RAM queue pointers, pairwise comparator.
// CSR: waitrequest drops for one cycle at least one cycle after the strobe; comparator: 3 cycles per pair.
// A comparator status post beats a CPU access in the same cycle, which then stalls one extra cycle.
module fprint_compare_unit #(
    parameter int KEY_WIDTH  = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int CRC_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [9:0]                  csr_address,
    input  logic                        csr_read,
    input  logic                        csr_write,
    input  logic [31:0]                 csr_writedata,
    output logic [31:0]                 csr_readdata,
    output logic                        csr_waitrequest,
    output logic                        irq,
    input  logic [3:0]                  asg_phys_core,
    input  logic [KEY_WIDTH-1:0]        asg_task,
    output logic                        asg_logical_core,
    output logic                        asg_valid,
    input  logic                        fp_push,
    output logic [ADDR_WIDTH-1:0]       fp_push_addr,
    input  logic [(1<<KEY_WIDTH)-1:0]   checkin,
    output logic [ADDR_WIDTH-1:0]       tail_addr0,
    output logic [ADDR_WIDTH-1:0]       tail_addr1,
    input  logic [CRC_WIDTH-1:0]        fprint0,
    input  logic [CRC_WIDTH-1:0]        fprint1
);
    localparam int NTASK = 1 << KEY_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_CMP} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] start_ptr [2][NTASK];
    logic [ADDR_WIDTH-1:0] end_ptr   [2][NTASK];
    logic [ADDR_WIDTH-1:0] head      [2][NTASK];
    logic [ADDR_WIDTH-1:0] tail      [2][NTASK];
    logic [3:0]            asg_tbl   [2][NTASK];
    logic [1:0][NTASK-1:0] asg_ok;

    logic [NTASK-1:0] success, fail, mismatch, cpend, checkin_q;
    logic [NTASK-1:0] ne0, ne1, ready, post_ok, blocked, post_vec;
    logic             exc, ack;
    logic [KEY_WIDTH-1:0] cur_task, last_task, pick_rdy, pick_post;
    logic             found_rdy, found_post, start_rd, post_now, cmp_adv;

    logic [1:0]           region;
    logic                 dir_hit, dir_wr_req, dir_busy, asg_hit, acc_wr, acc_rd;
    logic                 wr_start, wr_end, wr_asg, wr_exc, m0, m1, dir_c;
    logic [KEY_WIDTH-1:0] dir_k, asg_wr_task;
    logic                 unused_wdata;

    function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] p,
                                                       input logic [ADDR_WIDTH-1:0] s,
                                                       input logic [ADDR_WIDTH-1:0] e);
        return (p == e) ? s : p + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // CSR decode
    assign region      = csr_address[9:8];
    assign dir_c       = csr_address[6];
    assign dir_k       = csr_address[KEY_WIDTH-1:0];
    assign dir_hit     = !csr_address[7] && (int'(csr_address[5:0]) < NTASK);
    assign asg_hit     = (region == 2'd0) && !csr_address[7] && (csr_address[5:0] == 6'd3);
    assign acc_wr      = ack && csr_write;
    assign acc_rd      = ack && !csr_write && csr_read;
    assign wr_start    = acc_wr && dir_hit && (region == 2'd1);
    assign wr_end      = acc_wr && dir_hit && (region == 2'd2);
    assign wr_asg      = acc_wr && asg_hit;
    assign wr_exc      = acc_wr && (csr_address == 10'h000);
    assign asg_wr_task = csr_writedata[4 +: KEY_WIDTH];
    assign unused_wdata = ^csr_writedata[31:ADDR_WIDTH];

    // A pending directory write freezes its task for the comparator.
    assign dir_wr_req = csr_write && dir_hit && ((region == 2'd1) || (region == 2'd2));
    assign blocked    = dir_wr_req ? (NTASK'(1) << dir_k) : '0;
    assign dir_busy   = dir_wr_req && (state != ST_IDLE) && (dir_k == cur_task);

    assign csr_waitrequest = !ack;
    assign irq             = exc;

    always_comb begin
        csr_readdata = '0;
        if (acc_rd) begin
            if (csr_address == 10'h000)            csr_readdata = {31'b0, exc};
            else if (csr_address == 10'h001)       csr_readdata = 32'(success);
            else if (csr_address == 10'h002)       csr_readdata = 32'(fail);
            else if (dir_hit && region == 2'd1)    csr_readdata = 32'(start_ptr[dir_c][dir_k]);
            else if (dir_hit && region == 2'd2)    csr_readdata = 32'(end_ptr[dir_c][dir_k]);
        end
    end

    assign m0               = asg_ok[0][asg_task] && (asg_tbl[0][asg_task] == asg_phys_core);
    assign m1               = asg_ok[1][asg_task] && (asg_tbl[1][asg_task] == asg_phys_core);
    assign asg_valid        = m0 || m1;
    assign asg_logical_core = !m0 && m1;
    assign fp_push_addr     = head[asg_logical_core][asg_task];

    always_comb begin
        for (int t = 0; t < NTASK; t++) begin
            ne0[t] = head[0][t] != tail[0][t];
            ne1[t] = head[1][t] != tail[1][t];
        end
    end
    assign ready   = ne0 & ne1 & ~blocked;
    assign post_ok = cpend & ~ne0 & ~ne1 & ~blocked;

    // Round-robin from last serviced task + 1; posts go lowest-index first.
    always_comb begin
        found_rdy  = 1'b0;
        pick_rdy   = '0;
        found_post = 1'b0;
        pick_post  = '0;
        for (int i = 1; i <= NTASK; i++) begin
            if (!found_rdy && ready[last_task + KEY_WIDTH'(i)]) begin
                found_rdy = 1'b1;
                pick_rdy  = last_task + KEY_WIDTH'(i);
            end
        end
        for (int i = NTASK - 1; i >= 0; i--) begin
            if (post_ok[i]) begin
                found_post = 1'b1;
                pick_post  = KEY_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (found_rdy) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_CMP;
            ST_CMP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start_rd = 1'b0;
        post_now = 1'b0;
        cmp_adv  = 1'b0;
        case (state)
            ST_IDLE: begin
                start_rd = found_rdy;
                post_now = !found_rdy && found_post;
            end
            ST_CMP:  cmp_adv = 1'b1;
            default: ;
        endcase
    end
    assign post_vec = post_now ? (NTASK'(1) << pick_post) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack        <= 1'b0;
            exc        <= 1'b0;
            success    <= '0;
            fail       <= '0;
            mismatch   <= '0;
            cpend      <= '0;
            checkin_q  <= '0;
            cur_task   <= '0;
            last_task  <= '0;
            tail_addr0 <= '0;
            tail_addr1 <= '0;
        end else begin
            ack       <= (csr_read || csr_write) && !ack && !post_now && !dir_busy;
            checkin_q <= checkin;
            cpend     <= (cpend & ~post_vec) | (checkin_q & ~checkin);
            // CPU clear applies first so a same-cycle post is never lost.
            exc       <= (wr_exc ? 1'b0 : exc) | post_now;
            success   <= (wr_exc ? '0 : success) | (mismatch[pick_post] ? '0 : post_vec);
            fail      <= (wr_exc ? '0 : fail)    | (mismatch[pick_post] ? post_vec : '0);
            if (cmp_adv && (fprint0 != fprint1)) mismatch[cur_task] <= 1'b1;
            if (post_now) mismatch[pick_post] <= 1'b0;
            if (start_rd) begin
                cur_task   <= pick_rdy;
                last_task  <= pick_rdy;
                tail_addr0 <= tail[0][pick_rdy];
                tail_addr1 <= tail[1][pick_rdy];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asg_ok <= '0;
            for (int c = 0; c < 2; c++) begin
                for (int t = 0; t < NTASK; t++) begin
                    start_ptr[c][t] <= '0;
                    end_ptr[c][t]   <= '0;
                    head[c][t]      <= '0;
                    tail[c][t]      <= '0;
                    asg_tbl[c][t]   <= '0;
                end
            end
        end else begin
            if (fp_push && asg_valid)
                head[asg_logical_core][asg_task] <= ptr_next(head[asg_logical_core][asg_task],
                    start_ptr[asg_logical_core][asg_task], end_ptr[asg_logical_core][asg_task]);
            if (cmp_adv) begin
                tail[0][cur_task] <= ptr_next(tail[0][cur_task], start_ptr[0][cur_task], end_ptr[0][cur_task]);
                tail[1][cur_task] <= ptr_next(tail[1][cur_task], start_ptr[1][cur_task], end_ptr[1][cur_task]);
            end
            if (wr_start) begin
                start_ptr[dir_c][dir_k] <= csr_writedata[ADDR_WIDTH-1:0];
                head[dir_c][dir_k]      <= csr_writedata[ADDR_WIDTH-1:0];
                tail[dir_c][dir_k]      <= csr_writedata[ADDR_WIDTH-1:0];
            end
            if (wr_end) end_ptr[dir_c][dir_k] <= csr_writedata[ADDR_WIDTH-1:0];
            if (wr_asg) begin
                asg_tbl[dir_c][asg_wr_task] <= csr_writedata[3:0];
                asg_ok[dir_c][asg_wr_task]  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fprint_compare_unit.sv
// Randomized bench for fprint_compare_unit with a synchronous fingerprint RAM model and queue-level reference.
module tb_fprint_compare_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  csr_address;
    logic        csr_read, csr_write;
    logic [31:0] csr_writedata, csr_readdata;
    logic        csr_waitrequest, irq;
    logic [3:0]  asg_phys_core, asg_task;
    logic        asg_logical_core, asg_valid, fp_push;
    logic [9:0]  fp_push_addr, tail_addr0, tail_addr1;
    logic [15:0] checkin;
    logic [31:0] fprint0, fprint1, push_dat;
    logic [31:0] mem [1024];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fprint_compare_unit #(.KEY_WIDTH(4), .ADDR_WIDTH(10), .CRC_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .csr_waitrequest(csr_waitrequest), .irq(irq),
        .asg_phys_core(asg_phys_core), .asg_task(asg_task),
        .asg_logical_core(asg_logical_core), .asg_valid(asg_valid),
        .fp_push(fp_push), .fp_push_addr(fp_push_addr), .checkin(checkin),
        .tail_addr0(tail_addr0), .tail_addr1(tail_addr1),
        .fprint0(fprint0), .fprint1(fprint1)
    );

    // Fingerprint RAM: one write port fed by pushes, two registered read ports.
    always @(posedge clk) begin
        if (fp_push && asg_valid) mem[fp_push_addr] <= push_dat;
        fprint0 <= mem[tail_addr0];
        fprint1 <= mem[tail_addr1];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; csr_address = '0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
        asg_phys_core = '0; asg_task = '0; fp_push = 1'b0; checkin = '0; push_dat = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic csr_access(input logic wr, input logic [9:0] a, input logic [31:0] d,
                              output logic [31:0] rdat, output int waits);
        logic got_low;
        @(posedge clk); #1;
        csr_address = a; csr_write = wr; csr_read = !wr; csr_writedata = d;
        waits = 0; got_low = 1'b0; rdat = '0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            waits++;
            if (!csr_waitrequest) begin got_low = 1'b1; break; end
        end
        check_eq($sformatf("csr_ack_%03h", a), 32'(got_low), 32'd1);
        rdat = csr_readdata;
        if (got_low) begin
            @(posedge clk); #1;
        end
        csr_write = 1'b0; csr_read = 1'b0;
        check_eq($sformatf("csr_wait_hi_%03h", a), 32'(csr_waitrequest), 32'd1);
    endtask

    task automatic csr_wr(input logic [9:0] a, input logic [31:0] d);
        logic [31:0] unused_rd;
        int unused_w;
        csr_access(1'b1, a, d, unused_rd, unused_w);
    endtask

    task automatic csr_rd(input logic [9:0] a, output logic [31:0] r);
        int unused_w;
        csr_access(1'b0, a, 32'h0, r, unused_w);
    endtask

    task automatic push(input string tag, input logic [3:0] phys, input logic [3:0] tsk, input logic [31:0] dat,
                        input logic exp_vld, input logic exp_lc, input logic [9:0] exp_addr);
        @(posedge clk); #1;
        asg_phys_core = phys; asg_task = tsk; push_dat = dat; fp_push = 1'b1;
        #1;
        check_eq({tag, "_vld"}, 32'(asg_valid), 32'(exp_vld));
        if (exp_vld) begin
            check_eq({tag, "_lc"}, 32'(asg_logical_core), 32'(exp_lc));
            check_eq({tag, "_addr"}, 32'(fp_push_addr), 32'(exp_addr));
        end
        @(posedge clk); #1;
        fp_push = 1'b0;
    endtask

    task automatic wait_irq(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (irq) begin got = 1'b1; break; end
        end
        check_eq(tag, 32'(got), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int          waits, t, n, bad, i0, i1;
        logic [3:0]  p0, p1, q;
        logic [9:0]  s0, s1;
        logic [31:0] base, exp_s, exp_f;
        logic [31:0] fp0 [8];
        logic [31:0] fp1 [8];
        logic        any_diff;

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        do_reset();
        check_eq("rst_wait", 32'(csr_waitrequest), 32'd1);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_rdata", csr_readdata, 32'd0);
        check_eq("rst_asg_vld", 32'(asg_valid), 32'd0);
        check_eq("rst_tail0", 32'(tail_addr0), 32'd0);

        // Directory readback
        for (int k = 0; k < 16; k++) begin
            csr_wr(10'(32'h100 + k), 32'(k));
            csr_wr(10'(32'h200 + k), 32'(k));
        end
        for (int k = 0; k < 16; k++) begin
            csr_rd(10'(32'h100 + k), rd); check_eq($sformatf("rb_start%0d", k), rd, 32'(k));
            csr_rd(10'(32'h200 + k), rd); check_eq($sformatf("rb_end%0d", k), rd, 32'(k));
        end
        csr_rd(10'h3ff, rd);
        check_eq("unmapped_rd", rd, 32'd0);
        csr_wr(10'h003, 32'h013);
        csr_rd(10'h003, rd);
        check_eq("asg_rd_zero", rd, 32'd0);
        @(posedge clk); #1;
        asg_phys_core = 4'd3; asg_task = 4'd1; #1;
        check_eq("asg_hit_vld", 32'(asg_valid), 32'd1);
        check_eq("asg_hit_lc", 32'(asg_logical_core), 32'd0);
        asg_phys_core = 4'd4; #1;
        check_eq("asg_miss_vld", 32'(asg_valid), 32'd0);

        // Head wrap at end
        csr_wr(10'h003, 32'h005);
        csr_wr(10'h100, 32'd0); csr_wr(10'h200, 32'd3);
        csr_wr(10'h140, 32'd0); csr_wr(10'h240, 32'd3);
        for (int i = 0; i < 5; i++) push($sformatf("wrap%0d", i), 4'd5, 4'd0, 32'(i), 1'b1, 1'b0, 10'(i % 4));

        // Post collides with a CPU write
        do_reset();
        @(posedge clk); #1; checkin[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; checkin[2] = 1'b0;
        csr_access(1'b1, 10'h245, 32'h55, rd, waits);
        check_eq("arb_waits", 32'(waits), 32'd2);
        check_eq("arb_irq", 32'(irq), 32'd1);
        csr_access(1'b0, 10'h001, 32'h0, rd, waits);
        check_eq("arb_success", rd, 32'h4);
        check_eq("norm_waits", 32'(waits), 32'd1);
        csr_rd(10'h002, rd); check_eq("arb_fail", rd, 32'h0);
        csr_rd(10'h245, rd); check_eq("arb_end", rd, 32'h55);

        // Randomized compare rounds
        for (int r = 0; r < 8; r++) begin
            do_reset();
            t  = int'($urandom_range(0, 15));
            p0 = 4'($urandom_range(0, 15));
            p1 = p0 + 4'($urandom_range(1, 15));
            do q = 4'($urandom_range(0, 15)); while (q == p0 || q == p1);
            n    = int'($urandom_range(1, 6));
            bad  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
            base = $urandom;
            if (r == 0) begin n = 5; bad = -1; base = 32'hdeadbeef; end
            if (r == 1) begin n = 5; bad = 2;  base = 32'hdeadbeef; end
            s0 = 10'($urandom_range(0, 400));
            s1 = 10'($urandom_range(512, 900));
            for (int i = 0; i < n; i++) begin
                fp0[i] = base + 32'(i);
                fp1[i] = (i == bad) ? fp0[i] ^ (32'($urandom_range(1, 255)) << 3) : fp0[i];
            end
            any_diff = 1'b0;
            for (int i = 0; i < n; i++) if (fp0[i] != fp1[i]) any_diff = 1'b1;
            exp_s = any_diff ? 32'h0 : (32'h1 << t);
            exp_f = any_diff ? (32'h1 << t) : 32'h0;

            csr_wr(10'h003, {24'h0, 4'(t), p0});
            csr_wr(10'h043, {24'h0, 4'(t), p1});
            csr_wr(10'(32'h100 + t), 32'(s0)); csr_wr(10'(32'h200 + t), 32'(s0 + 10'd7));
            csr_wr(10'(32'h140 + t), 32'(s1)); csr_wr(10'(32'h240 + t), 32'(s1 + 10'd7));
            checkin[t] = 1'b1;
            push($sformatf("r%0d_nomap", r), q, 4'(t), 32'hbad0bad0, 1'b0, 1'b0, 10'h0);
            i0 = 0; i1 = 0;
            while (i0 < n || i1 < n) begin
                if (i1 >= n || (i0 < n && $urandom_range(0, 1) == 1)) begin
                    push($sformatf("r%0d_c0_%0d", r, i0), p0, 4'(t), fp0[i0], 1'b1, 1'b0, s0 + 10'(i0 % 8));
                    i0++;
                end else begin
                    push($sformatf("r%0d_c1_%0d", r, i1), p1, 4'(t), fp1[i1], 1'b1, 1'b1, s1 + 10'(i1 % 8));
                    i1++;
                end
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            repeat (5) @(posedge clk);
            #1 checkin[t] = 1'b0;
            wait_irq($sformatf("r%0d_irq", r));
            check_eq($sformatf("r%0d_tail0", r), 32'(tail_addr0), 32'(s0 + 10'(n - 1)));
            check_eq($sformatf("r%0d_tail1", r), 32'(tail_addr1), 32'(s1 + 10'(n - 1)));
            csr_rd(10'h001, rd); check_eq($sformatf("r%0d_success", r), rd, exp_s);
            csr_rd(10'h002, rd); check_eq($sformatf("r%0d_fail", r), rd, exp_f);
            csr_rd(10'h000, rd); check_eq($sformatf("r%0d_exc", r), rd, 32'h1);
            csr_wr(10'h000, $urandom);
            csr_rd(10'h000, rd); check_eq($sformatf("r%0d_exc_clr", r), rd, 32'h0);
            csr_rd(10'h001, rd); check_eq($sformatf("r%0d_succ_clr", r), rd, 32'h0);
            csr_rd(10'h002, rd); check_eq($sformatf("r%0d_fail_clr", r), rd, 32'h0);
            check_eq($sformatf("r%0d_irq_clr", r), 32'(irq), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
